// File: rtl/bbqm_pkg.sv
// Shared types and constants for the BBqM display path.
// Widths, blank pattern, slot indices and converter states.
package bbqm_pkg;

    localparam int PCOUNT_W = 3;
    localparam int WTIME_W  = 5;

    localparam logic [6:0] BLANK = 7'b0000000;

    localparam logic [1:0] SLOT_PCNT0 = 2'd0;
    localparam logic [1:0] SLOT_PCNT1 = 2'd1;
    localparam logic [1:0] SLOT_WT0   = 2'd2;
    localparam logic [1:0] SLOT_WT1   = 2'd3;

    typedef enum logic [1:0] {
        CONV_IDLE = 2'd0,
        CONV_LOAD = 2'd1,
        CONV_SUB  = 2'd2,
        CONV_DONE = 2'd3
    } conv_state_t;

    function automatic logic [3:0] onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative 5-bit binary to BCD converter by repeated subtract-10.
// At most six cycles from start to done.
module bin2bcd_iter
    import bbqm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WTIME_W-1:0] bin,
    output logic               done,
    output logic [1:0]         tens,
    output logic [3:0]         units
);

    conv_state_t        state_q, state_d;
    logic [WTIME_W-1:0] rem_q, rem_d;
    logic [1:0]         acc_q, acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CONV_IDLE;
            rem_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        done    = 1'b0;
        unique case (state_q)
            CONV_IDLE: begin
                if (start) state_d = CONV_LOAD;
            end
            CONV_LOAD: begin
                rem_d   = bin;
                acc_d   = 2'd0;
                state_d = CONV_SUB;
            end
            CONV_SUB: begin
                if (rem_q >= WTIME_W'(10)) begin
                    rem_d = rem_q - WTIME_W'(10);
                    acc_d = acc_q + 2'd1;
                end else begin
                    state_d = CONV_DONE;
                end
            end
            CONV_DONE: begin
                done    = 1'b1;
                state_d = CONV_IDLE;
            end
        endcase
    end

    assign tens  = acc_q;
    assign units = rem_q[3:0];

endmodule

// File: rtl/sevenSegments.sv
// Hex-to-seven-segment decoder, active-high segments {g,f,e,d,c,b,a}.
// Digits above 9 decode to blank.
module sevenSegments (
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    always_comb begin
        segments = 7'b0000000;
        case (digit)
            4'd0: segments = 7'b0111111;
            4'd1: segments = 7'b0000110;
            4'd2: segments = 7'b1011011;
            4'd3: segments = 7'b1001111;
            4'd4: segments = 7'b1100110;
            4'd5: segments = 7'b1101101;
            4'd6: segments = 7'b1111101;
            4'd7: segments = 7'b0000111;
            4'd8: segments = 7'b1111111;
            4'd9: segments = 7'b1101111;
            default: segments = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed seven-segment driver for queue count and wait time.
// One shared decoder, per-frame snapshot, blanking between digit slots.
module display_scanner
    import bbqm_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PCOUNT_W-1:0] Pcount,
    input  logic [WTIME_W-1:0]  Wtime,
    input  logic                full,
    output logic [6:0]          seg,
    output logic [3:0]          anode
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]    pre;
    logic [1:0]          slot;
    logic [PCOUNT_W-1:0] shadow_p;
    logic [WTIME_W-1:0]  shadow_w;
    logic [3:0]          units_q;
    logic [1:0]          tens_q;
    logic [FC_W-1:0]     fcnt;
    logic                blink_on;

    logic       pre_zero, pre_wrap;
    logic       frame_start, frame_end;
    logic       conv_done;
    logic [1:0] conv_tens;
    logic [3:0] conv_units;
    logic [3:0] digit;
    logic       blank;
    logic [6:0] dec_seg;
    logic [6:0] seg_d;

    assign pre_zero    = (pre == '0);
    assign pre_wrap    = (pre == PRE_LAST);
    assign frame_start = pre_zero && (slot == SLOT_PCNT0);
    assign frame_end   = pre_wrap && (slot == SLOT_WT1);

    bin2bcd_iter u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (frame_start),
        .bin   (shadow_w),
        .done  (conv_done),
        .tens  (conv_tens),
        .units (conv_units)
    );

    // Slot 0 reads the shadow before this frame's capture lands.
    always_comb begin
        digit = 4'd0;
        blank = 1'b1;
        unique case (slot)
            SLOT_PCNT0: begin
                digit = {1'b0, shadow_p};
                blank = full && !blink_on;
            end
            SLOT_PCNT1: blank = 1'b1;
            SLOT_WT0: begin
                digit = units_q;
                blank = 1'b0;
            end
            SLOT_WT1: begin
                digit = {2'b00, tens_q};
                blank = (tens_q == 2'd0);
            end
        endcase
    end

    sevenSegments u_dec (
        .digit    (digit),
        .segments (dec_seg)
    );

    assign seg_d = blank ? BLANK : dec_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre      <= '0;
            slot     <= SLOT_PCNT0;
            shadow_p <= '0;
            shadow_w <= '0;
            units_q  <= '0;
            tens_q   <= '0;
            fcnt     <= '0;
            blink_on <= 1'b1;
            seg      <= BLANK;
            anode    <= 4'b0000;
        end else begin
            pre <= pre_wrap ? '0 : pre + 1'b1;
            if (pre_wrap) slot <= slot + 2'd1;
            if (frame_start) begin
                shadow_p <= Pcount;
                shadow_w <= Wtime;
            end
            if (conv_done) begin
                units_q <= conv_units;
                tens_q  <= conv_tens;
            end
            if (frame_end) begin
                if (fcnt == FC_LAST) begin
                    fcnt     <= '0;
                    blink_on <= ~blink_on;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
            if (pre_zero) seg <= seg_d;
            anode <= pre_zero ? 4'b0000 : onehot(slot);
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner against a frame-level model.
// Directed scenarios followed by randomized input changes.
module tb_display_scanner;
    import bbqm_pkg::*;

    localparam int R = 8;
    localparam int B = 2;
    localparam int F = 4 * R;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] Pcount;
    logic [4:0] Wtime;
    logic       full;
    logic [6:0] seg;
    logic [3:0] anode;

    int total = 0;
    int bad   = 0;

    int k;
    int cap_p, cap_w;
    int conv_k;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;

    display_scanner #(.REFRESH_DIV(R), .BLINK_FRAMES(B)) dut (
        .clk    (clk),
        .rst    (rst),
        .Pcount (Pcount),
        .Wtime  (Wtime),
        .full   (full),
        .seg    (seg),
        .anode  (anode)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input int d);
        logic [6:0] t [10];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (d >= 0 && d <= 9) ? t[d] : 7'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k       = 0;
        cap_p   = 0;
        cap_w   = 0;
        conv_k  = -1;
        exp_seg = 7'h00;
        exp_an  = 4'h0;
    endtask

    task automatic tick();
        int pre, slot, frame;
        bit blink;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            pre   = k % R;
            slot  = (k / R) % 4;
            frame = k / F;
            blink = ((frame / B) % 2) == 0;
            if (pre == 0) begin
                case (slot)
                    0: begin
                        exp_seg = (full && !blink) ? 7'h00 : dec(cap_p);
                        cap_p = int'(Pcount);
                        cap_w = int'(Wtime);
                    end
                    1: exp_seg = 7'h00;
                    2: exp_seg = dec(cap_w % 10);
                    default: exp_seg = (cap_w / 10 == 0) ? 7'h00 : dec(cap_w / 10);
                endcase
            end
            exp_an = (pre == 0) ? 4'h0 : 4'(1 << slot);
            conv_k = k % F;
            k++;
        end
        #1;
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("anode", 32'(anode), 32'(exp_an));
        if (!rst && conv_k == 6) begin
            chk("units", 32'(dut.units_q), 32'(cap_w % 10));
            chk("tens", 32'(dut.tens_q), 32'(cap_w / 10));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic align(input int pos);
        for (int i = 0; i < F && (k % F) != pos; i++) tick();
    endtask

    task automatic scenario_a();
        Pcount = 3'd0;
        Wtime  = 5'd0;
        full   = 1'b0;
        run(F);
        Pcount = 3'd5;
        Wtime  = 5'd27;
        run(2 * F);
    endtask

    initial begin
        rst    = 1'b1;
        Pcount = 3'd0;
        Wtime  = 5'd0;
        full   = 1'b0;
        model_reset();
        run(3);
        #1 rst = 1'b0;

        scenario_a();

        Wtime = 5'd9;
        run(2 * F);
        Wtime = 5'd10;
        run(2 * F);
        Wtime = 5'd31;
        run(2 * F);

        align(2 * R + 3);
        Wtime = 5'd4;
        run(2 * F);

        Pcount = 3'd6;
        Wtime  = 5'd18;
        full   = 1'b1;
        run(8 * F);
        full = 1'b0;
        run(3 * F);

        for (int i = 0; i < 24 * F; i++) begin
            if ($urandom_range(15) == 0) Pcount = 3'($urandom_range(7));
            if ($urandom_range(15) == 0) Wtime  = 5'($urandom_range(31));
            if ($urandom_range(31) == 0) full   = ~full;
            tick();
        end

        full  = 1'b0;
        Wtime = 5'd31;
        align(0);
        run(F);
        align(3);
        rst = 1'b1;
        tick();
        chk("conv_idle", 32'(dut.u_bcd.state_q), 32'(CONV_IDLE));
        chk("units_rst", 32'(dut.units_q), 32'd0);
        chk("tens_rst", 32'(dut.tens_q), 32'd0);
        run(2);
        rst = 1'b0;
        scenario_a();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed driver for the BBqM four-digit seven-segment display. It shows Pcount (people in queue) and Wtime (estimated wait) through one shared seven-segment decoder instead of four. Each frame it snapshots the queue values, converts Wtime to BCD with an iterative divide-by-10, and cycles one-hot digit enables with inter-digit blanking. It sits between the queue counter/wait-time logic and the board's common-anode digit pins.

## Interface
- REFRESH_DIV, default 50000: clock cycles per digit slot. Must be ≥ 8.
- BLINK_FRAMES, default 64: frames per blink half-period.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- Pcount  in  3  queue occupancy, 0..7.
- Wtime  in  5  wait time, 0..31.
- full  in  1  queue-full flag from the queue counter.
- seg  out  7  segment pattern, registered; sevenSegments encoding; blank = 7'b0000000.
- anode  out  4  digit enable, registered, one-hot or all-zero; bit0 = Pcount units, bit1 = Pcount tens, bit2 = Wtime units, bit3 = Wtime tens.

## Operation
- Prescaler `pre` counts 0..REFRESH_DIV-1. Slot counter `slot` counts 0..3 and advances when `pre` wraps. A frame is slots 0→3.
- Frame start (`slot`=0, `pre`=0): capture Pcount and Wtime into shadow registers, then start the converter.
- Converter FSM:
  - IDLE → LOAD on frame start.
  - LOAD: rem=shadow Wtime, tens=0 → SUB.
  - SUB: if rem ≥ 10, then rem -= 10 and tens += 1, stay in SUB; else → DONE.
  - DONE: write tens (2 bits) and units (4 bits) to the digit registers in one cycle → IDLE.
  - Worst case (31) is LOAD + 4×SUB + DONE = 6 cycles, so conversion always finishes inside slot 0.
- Digit value per slot:
  - Slot 0: {0,Pcount}.
  - Slot 1: always blank. Pcount ≤ 7, so this is leading-zero suppression.
  - Slot 2: units.
  - Slot 3: tens, blank when tens=0.
- Blink: a frame counter toggles `blink_on` every BLINK_FRAMES frames. While full=1 and blink_on=0, slot 0 is blank. When full=0, slot 0 always shows. The full signal is sampled live, not snapshotted.
- The mux output feeds one combinational sevenSegments instance. Its output, or 0 for blank, is registered into seg.
- Anti-ghosting: for `pre`=0 of every slot, anode=4'b0000 while seg loads the new pattern. For `pre`≥1, anode=one-hot(slot).
- Input changes mid-frame have no effect until the next frame start.

## Timing
- Reset values: seg=0, anode=0, pre=0, slot=0, shadows=0, units=tens=0, converter IDLE, blink_on=1, frame counter=0.
- seg and anode are one register stage after `pre`/`slot`. The pattern for slot k appears on the same cycle anode goes to 0000 for that slot.
- First frame after reset shows 0 in slots 0 and 2. New values are visible from slot 2 of the frame that captured them.
- rst asserted mid-conversion aborts it: no partial digit update, and the FSM returns to IDLE next cycle.
- Frame period is 4×REFRESH_DIV cycles. Blink period is 2×BLINK_FRAMES frames.

## Structure
- Shared package/header `bbqm_pkg` holds:
  - BLANK pattern constant.
  - Converter state encodings (IDLE, LOAD, SUB, DONE).
  - Slot indices (SLOT_PCNT0, SLOT_PCNT1, SLOT_WT0, SLOT_WT1).
  - Widths PCOUNT_W=3, WTIME_W=5.
- One sub-module: `bin2bcd_iter`, holding the converter FSM with a start/done handshake and a 5-bit input giving 2-bit tens and 4-bit units.
- Reuse the existing `sevenSegments` decoder, instantiated once.

## Test plan
Bench parameters: REFRESH_DIV=8, BLINK_FRAMES=2.
- Reset: rst high for 3 cycles → seg=0 and anode=0 during reset. After release, anode sequences 0000, 0001×7, 0000, 0010×7, …
- Pcount=5, Wtime=27 → slot 0 shows decode(5), slot 1 blank, slot 2 decode(7), slot 3 decode(2). Converter done ≤6 cycles after frame start.
- Wtime=9 → slot 3 blank. Wtime=10 → slot 3 decode(1), slot 2 decode(0). Wtime=31 → tens=3, units=1.
- Wtime changed 31→4 during slot 2 → display keeps 3/1 through slot 3 and shows 4 with blank tens from the next frame.
- full=1 → slot 0 blank for 2 frames, shown for 2 frames, repeating. Other digits unaffected. full=0 → slot 0 steady.
- rst pulsed during the SUB state with Wtime=31 → no digit register change. After release, the outputs and internal state restart exactly as in the first scenario.
